// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes and responder state encodings.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a master and the memory responder.
interface axi4_lite_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] s_awaddr;
  logic                  s_awvalid;
  logic                  s_awready;
  logic [31:0]           s_wdata;
  logic [3:0]            s_wstrb;
  logic                  s_wvalid;
  logic                  s_wready;
  logic [1:0]            s_bresp;
  logic                  s_bvalid;
  logic                  s_bready;
  logic [ADDR_WIDTH-1:0] s_araddr;
  logic                  s_arvalid;
  logic                  s_arready;
  logic [31:0]           s_rdata;
  logic [1:0]            s_rresp;
  logic                  s_rvalid;
  logic                  s_rready;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

endinterface

// File: rtl/byte_en_ram.sv
// Word-wide RAM: one byte-enabled write port, one synchronous read port, read-before-write.
module byte_en_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Non-blocking read and write on the same edge yields the pre-write word.
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_lite_mem_slave.sv
// AXI4-Lite memory responder: independent AW/W capture, single outstanding write and read.
module axi4_lite_mem_slave
  import axi4_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic                  clk,
  input logic                  rst,
  axi4_lite_mem_slave_if.slave s
);

  localparam int unsigned IdxW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return 64'(off) < (64'(MEM_DEPTH) << 2);
  endfunction

  function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return off[IdxW+1:2];
  endfunction

  // Held low until the first edge after reset release so readies never glitch high in reset.
  logic rdy_en_q;

  wr_state_e             wstate_q, wstate_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  awready, wready, aw_hs, w_hs, commit, aw_ok;

  rd_state_e rstate_q, rstate_d;
  logic      rvalid_q, rvalid_d, rin_q, rin_d;
  logic [1:0] rresp_q, rresp_d;
  logic      arready, ar_hs, ar_ok;
  logic [31:0] ram_rdata;

  assign awready = rdy_en_q & ~aw_held_q & ~bvalid_q;
  assign wready  = rdy_en_q & ~w_held_q & ~bvalid_q;
  assign arready = rdy_en_q & (rstate_q == R_IDLE);
  assign aw_hs   = s.s_awvalid & awready;
  assign w_hs    = s.s_wvalid & wready;
  assign ar_hs   = s.s_arvalid & arready;
  assign commit  = (wstate_q != W_RESP) & aw_held_q & w_held_q;
  assign aw_ok   = in_range(awaddr_q);
  assign ar_ok   = in_range(s.s_araddr);

  always_comb begin
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s.s_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s.s_wdata;
      wstrb_d  = s.s_wstrb;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (bvalid_q && s.s_bready) begin
      bvalid_d = 1'b0;
    end
    // Both-held (awaiting commit) is tracked by the flags; the state then reads W_HAVE_ADDR.
    if (bvalid_d)       wstate_d = W_RESP;
    else if (aw_held_d) wstate_d = W_HAVE_ADDR;
    else if (w_held_d)  wstate_d = W_HAVE_DATA;
    else                wstate_d = W_IDLE;
  end

  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rin_d    = rin_q;
    unique case (rstate_q)
      R_IDLE: begin
        if (ar_hs) begin
          rstate_d = R_RESP;
          rvalid_d = 1'b1;
          rin_d    = ar_ok;
          rresp_d  = ar_ok ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (s.s_rready) begin
          rstate_d = R_IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q  <= 1'b0;
      wstate_q  <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rin_q     <= 1'b0;
    end else begin
      rdy_en_q  <= 1'b1;
      wstate_q  <= wstate_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rin_q     <= rin_d;
    end
  end

  byte_en_ram #(
    .Depth (MEM_DEPTH),
    .AddrW (IdxW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (commit & aw_ok),
    .be_i    (wstrb_q),
    .waddr_i (word_idx(awaddr_q)),
    .wdata_i (wdata_q),
    .re_i    (ar_hs & ar_ok),
    .raddr_i (word_idx(s.s_araddr)),
    .rdata_o (ram_rdata)
  );

  assign s.s_awready = awready;
  assign s.s_wready  = wready;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_arready = arready;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rresp   = rresp_q;
  // RAM output register is not reset, so gate it; it only changes on an AR handshake.
  assign s.s_rdata   = (rvalid_q & rin_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_axi4_lite_mem_slave.sv
// Directed bench for axi4_lite_mem_slave with hand-computed expectations.
module tb_axi4_lite_mem_slave;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errs    = 0;

  axi4_lite_mem_slave_if #(.ADDR_WIDTH(32)) bus ();

  axi4_lite_mem_slave #(
    .ADDR_WIDTH (32),
    .MEM_DEPTH  (1024),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    logic aw_hs, w_hs, b_hs;
    bit   done = 0;
    resp = 2'bxx;
    bus.s_awaddr  = addr;
    bus.s_wdata   = data;
    bus.s_wstrb   = strb;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    bus.s_bready  = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      aw_hs = bus.s_awvalid && bus.s_awready;
      w_hs  = bus.s_wvalid && bus.s_wready;
      b_hs  = bus.s_bvalid && bus.s_bready;
      if (b_hs) resp = bus.s_bresp;
      tick();
      if (aw_hs) bus.s_awvalid = 1'b0;
      if (w_hs)  bus.s_wvalid  = 1'b0;
      if (b_hs)  done = 1;
    end
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    chk("wr_complete", 32'(done), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    logic ar_hs, r_hs;
    bit   done  = 0;
    int   since = -1;
    data = 'x;
    resp = 2'bxx;
    lat  = -1;
    bus.s_araddr  = addr;
    bus.s_arvalid = 1'b1;
    bus.s_rready  = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      ar_hs = bus.s_arvalid && bus.s_arready;
      r_hs  = bus.s_rvalid && bus.s_rready;
      if (r_hs) begin
        data = bus.s_rdata;
        resp = bus.s_rresp;
      end
      tick();
      if (ar_hs) begin
        bus.s_arvalid = 1'b0;
        since = 0;
      end
      if (since >= 0) since++;
      if (bus.s_rvalid && lat < 0 && since >= 0) lat = since;
      if (r_hs) done = 1;
    end
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    chk("rd_complete", 32'(done), 32'd1);
  endtask

  logic [1:0]  resp;
  logic [31:0] rd;
  int          lat;

  initial begin
    rst           = 1'b0;
    bus.s_awaddr  = '0;
    bus.s_awvalid = 1'b0;
    bus.s_wdata   = '0;
    bus.s_wstrb   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_bready  = 1'b0;
    bus.s_araddr  = '0;
    bus.s_arvalid = 1'b0;
    bus.s_rready  = 1'b0;
    #2;
    chk("rst_awready", 32'(bus.s_awready), 32'd0);
    chk("rst_wready",  32'(bus.s_wready),  32'd0);
    chk("rst_arready", 32'(bus.s_arready), 32'd0);
    chk("rst_bvalid",  32'(bus.s_bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.s_rvalid),  32'd0);
    chk("rst_bresp",   32'(bus.s_bresp),   32'd0);
    chk("rst_rresp",   32'(bus.s_rresp),   32'd0);
    chk("rst_rdata",   bus.s_rdata,        32'd0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("release_awready_low", 32'(bus.s_awready), 32'd0);
    tick();
    chk("release_awready_up", 32'(bus.s_awready), 32'd1);
    chk("release_arready_up", 32'(bus.s_arready), 32'd1);

    // AW first, W two cycles later
    bus.s_bready  = 1'b1;
    bus.s_awaddr  = 32'h10;
    bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    chk("aw_held_awready", 32'(bus.s_awready), 32'd0);
    chk("aw_held_wready",  32'(bus.s_wready),  32'd1);
    tick();
    tick();
    bus.s_wdata  = 32'hDEAD_BEEF;
    bus.s_wstrb  = 4'hF;
    bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    chk("b_not_same_edge", 32'(bus.s_bvalid), 32'd0);
    tick();
    chk("b_one_after_w", 32'(bus.s_bvalid), 32'd1);
    chk("b_okay",        32'(bus.s_bresp),  32'd0);
    tick();
    bus.s_bready = 1'b0;
    chk("b_dropped", 32'(bus.s_bvalid), 32'd0);
    do_read(32'h10, rd, resp, lat);
    chk("rd10_data",    rd,         32'hDEAD_BEEF);
    chk("rd10_resp",    32'(resp),  32'd0);
    chk("rd10_latency", 32'(lat),   32'd1);

    // W first, partial strobe
    bus.s_bready = 1'b1;
    bus.s_wdata  = 32'h0000_AB00;
    bus.s_wstrb  = 4'b0010;
    bus.s_wvalid = 1'b1;
    tick();
    bus.s_wvalid = 1'b0;
    chk("w_held_wready",  32'(bus.s_wready),  32'd0);
    chk("w_held_awready", 32'(bus.s_awready), 32'd1);
    tick();
    bus.s_awaddr  = 32'h10;
    bus.s_awvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    chk("wfirst_b_wait", 32'(bus.s_bvalid), 32'd0);
    tick();
    chk("wfirst_bvalid", 32'(bus.s_bvalid), 32'd1);
    chk("wfirst_bresp",  32'(bus.s_bresp),  32'd0);
    tick();
    bus.s_bready = 1'b0;
    do_read(32'h10, rd, resp, lat);
    chk("strb_merge", rd, 32'hDEAD_ABEF);

    // Range boundaries, zero strobe and ignored low address bits
    do_write(32'h0, 32'hCAFE_F00D, 4'hF, resp);
    chk("wr0_resp", 32'(resp), 32'd0);
    do_write(32'h1000, 32'h1234_5678, 4'hF, resp);
    chk("oor_wr_resp", 32'(resp), 32'd2);
    do_read(32'h1000, rd, resp, lat);
    chk("oor_rd_data", rd,        32'd0);
    chk("oor_rd_resp", 32'(resp), 32'd2);
    do_read(32'h0, rd, resp, lat);
    chk("oor_no_alias", rd, 32'hCAFE_F00D);
    do_write(32'hFFC, 32'hA5A5_A5A5, 4'hF, resp);
    chk("last_wr_resp", 32'(resp), 32'd0);
    do_read(32'hFFC, rd, resp, lat);
    chk("last_rd_data", rd,        32'hA5A5_A5A5);
    chk("last_rd_resp", 32'(resp), 32'd0);
    do_write(32'h13, 32'h7777_7777, 4'h0, resp);
    chk("strb0_resp", 32'(resp), 32'd0);
    do_read(32'h12, rd, resp, lat);
    chk("strb0_unchanged", rd, 32'hDEAD_ABEF);

    // B back-pressure
    bus.s_awaddr  = 32'h40;
    bus.s_wdata   = 32'h5A5A_0001;
    bus.s_wstrb   = 4'hF;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bstall_bvalid",  32'(bus.s_bvalid),  32'd1);
      chk("bstall_bresp",   32'(bus.s_bresp),   32'd0);
      chk("bstall_awready", 32'(bus.s_awready), 32'd0);
      chk("bstall_wready",  32'(bus.s_wready),  32'd0);
      tick();
    end
    bus.s_bready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    chk("bstall_release", 32'(bus.s_bvalid), 32'd0);

    // R back-pressure
    bus.s_araddr  = 32'h40;
    bus.s_arvalid = 1'b1;
    tick();
    bus.s_arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstall_rvalid",  32'(bus.s_rvalid),  32'd1);
      chk("rstall_rdata",   bus.s_rdata,        32'h5A5A_0001);
      chk("rstall_arready", 32'(bus.s_arready), 32'd0);
      tick();
    end
    bus.s_rready = 1'b1;
    tick();
    bus.s_rready = 1'b0;
    chk("rstall_release", 32'(bus.s_rvalid), 32'd0);
    chk("rstall_arready", 32'(bus.s_arready), 32'd1);

    // Commit and read of the same word on one edge
    do_write(32'h20, 32'h2222_2222, 4'hF, resp);
    bus.s_awaddr  = 32'h20;
    bus.s_wdata   = 32'h1111_1111;
    bus.s_wstrb   = 4'hF;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_araddr  = 32'h20;
    bus.s_arvalid = 1'b1;
    tick();
    bus.s_arvalid = 1'b0;
    chk("rbw_bvalid", 32'(bus.s_bvalid), 32'd1);
    chk("rbw_rvalid", 32'(bus.s_rvalid), 32'd1);
    chk("rbw_old",    bus.s_rdata,       32'h2222_2222);
    bus.s_bready = 1'b1;
    bus.s_rready = 1'b1;
    tick();
    bus.s_bready = 1'b0;
    bus.s_rready = 1'b0;
    do_read(32'h20, rd, resp, lat);
    chk("rbw_new", rd, 32'h1111_1111);

    // Reset with both responses pending
    bus.s_awaddr  = 32'h30;
    bus.s_wdata   = 32'h0000_0001;
    bus.s_wstrb   = 4'hF;
    bus.s_araddr  = 32'h30;
    bus.s_awvalid = 1'b1;
    bus.s_wvalid  = 1'b1;
    bus.s_arvalid = 1'b1;
    tick();
    bus.s_awvalid = 1'b0;
    bus.s_wvalid  = 1'b0;
    bus.s_arvalid = 1'b0;
    tick();
    chk("pre_rst_bvalid", 32'(bus.s_bvalid), 32'd1);
    chk("pre_rst_rvalid", 32'(bus.s_rvalid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_bvalid",  32'(bus.s_bvalid),  32'd0);
    chk("mid_rst_rvalid",  32'(bus.s_rvalid),  32'd0);
    chk("mid_rst_awready", 32'(bus.s_awready), 32'd0);
    chk("mid_rst_arready", 32'(bus.s_arready), 32'd0);
    chk("mid_rst_rdata",   bus.s_rdata,        32'd0);
    tick();
    rst = 1'b1;
    tick();
    do_write(32'h30, 32'h0BAD_CAFE, 4'hF, resp);
    chk("post_rst_bresp", 32'(resp), 32'd0);
    do_read(32'h30, rd, resp, lat);
    chk("post_rst_rdata", rd,        32'h0BAD_CAFE);
    chk("post_rst_rresp", 32'(resp), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/axi4_lite_mem_slave.md
AXI4_LITE_MEM_SLAVE -- requirements
Module: axi4_lite_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, number of 32-bit words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 SHALL have port clk, input, 1, single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous assert, active-low.
REQ-006 SHALL have port s_awaddr, input, ADDR_WIDTH, write address.
REQ-007 SHALL have port s_awvalid, input, 1, write address valid.
REQ-008 SHALL have port s_awready, output, 1, write address ready.
REQ-009 SHALL have port s_wdata, input, 32, write data.
REQ-010 SHALL have port s_wstrb, input, 4, byte enables; bit i selects wdata[8i+7:8i].
REQ-011 SHALL have port s_wvalid, input, 1, write data valid.
REQ-012 SHALL have port s_wready, output, 1, write data ready.
REQ-013 SHALL have port s_bresp, output, 2, write response.
REQ-014 SHALL have port s_bvalid, output, 1, write response valid.
REQ-015 SHALL have port s_bready, input, 1, write response ready.
REQ-016 SHALL have port s_araddr, input, ADDR_WIDTH, read address.
REQ-017 SHALL have port s_arvalid, input, 1, read address valid.
REQ-018 SHALL have port s_arready, output, 1, read address ready.
REQ-019 SHALL have port s_rdata, output, 32, read data.
REQ-020 SHALL have port s_rresp, output, 2, read response.
REQ-021 SHALL have port s_rvalid, output, 1, read data valid.
REQ-022 SHALL have port s_rready, input, 1, read data ready.

Function
REQ-023 SHALL be an AXI4-Lite responder; handshake on a channel = valid & ready high at a rising edge.
REQ-024 SHALL accept AW and W independently, in either order or in the same cycle, holding each in a register plus held flag.
REQ-025 SHALL drive s_awready = !aw_held & !s_bvalid and s_wready = !w_held & !s_bvalid; at most one write outstanding.
REQ-026 SHALL write states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP; W_RESP entered the cycle after both AW and W are held, committing the write on that edge.
REQ-027 SHALL assert s_bvalid exactly 1 clock after the later of the AW/W handshakes and hold it with s_bresp stable until s_bready; return to W_IDLE on that handshake.
REQ-028 SHALL compute word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored; in-range iff (addr - BASE_ADDR) < MEM_DEPTH*4, unsigned, no wrap.
REQ-029 SHALL on out-of-range write leave memory unchanged and return SLVERR (2'b10); otherwise update only strobed bytes and return OKAY (2'b00); wstrb=0 is OKAY with no change.
REQ-030 SHALL read states: R_IDLE, R_RESP; s_arready = (state==R_IDLE).
REQ-031 SHALL on AR handshake enter R_RESP next clock with s_rvalid=1, s_rdata=memory word (1-cycle latency), s_rresp=OKAY.
REQ-032 SHALL on out-of-range read return s_rdata=0, s_rresp=SLVERR.
REQ-033 SHALL hold s_rdata/s_rresp stable while s_rvalid & !s_rready; return to R_IDLE on R handshake (next AR accepted one cycle later).
REQ-034 SHALL run read and write paths concurrently; read sampling and write commit to the same word on the same edge returns old data.
REQ-035 SHALL never combinationally depend ready outputs on any valid input.

Reset
REQ-036 SHALL on rst low immediately drive s_awready, s_wready, s_arready, s_bvalid, s_rvalid = 0, s_bresp = s_rresp = 0, s_rdata = 0, states to IDLE, held flags cleared; in-flight transactions are dropped.
REQ-037 SHALL not reset memory contents; ready outputs rise the first clock after rst deasserts.

Structure
REQ-038 SHALL take RESP_OKAY, RESP_SLVERR and write/read state enums from shared package axi4_lite_pkg.
REQ-039 SHALL place storage in sub-module byte_en_ram (one write port with 4-bit byte enables, one synchronous read port, read-before-write).

Verification
REQ-040 AW 0x10 then W 0xDEADBEEF strb 4'hF two cycles later, bready=1 -> bvalid one clock after W handshake, bresp=00; read 0x10 -> rdata 0xDEADBEEF, rresp=00 one clock after AR.
REQ-041 W before AW, then strb 4'b0010 data 0x0000AB00 to 0x10 -> read returns 0xDEADABEF.
REQ-042 Write to BASE_ADDR+MEM_DEPTH*4 -> bresp=10, memory unchanged; read same -> rdata 0, rresp=10.
REQ-043 bready low 5 cycles -> bvalid, bresp held, awready/wready stay 0; rready low 3 cycles -> rdata stable, arready 0.
REQ-044 Simultaneous commit of 0x11111111 and read of same word holding 0x22222222 -> read returns 0x22222222, later read 0x11111111.
REQ-045 rst low while bvalid and rvalid high -> both drop immediately; after release, new write/read complete normally.
